// File: rtl/axi4_slave_pkg.sv
// rtl/axi4_slave_pkg.sv - arbiter state and ownership types shared by the memory arbiter
package axi4_slave_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_WR, ARB_RD} arb_state_t;
   typedef enum logic {OWN_WR, OWN_RD} arb_owner_t;

endpackage

// File: rtl/axi4_rd_valid_pipe.sv
// rtl/axi4_rd_valid_pipe.sv - RD_LATENCY-deep valid shift register with synchronous clear
module axi4_rd_valid_pipe #(
   parameter int RD_LATENCY = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic out_valid
);

   logic [RD_LATENCY-1:0] stages;

   always_ff @(posedge clk) begin
      if (rst) begin
         stages <= '0;
      end else begin
         stages <= (stages << 1) | RD_LATENCY'(in_valid);
      end
   end

   assign out_valid = stages[RD_LATENCY-1];

endmodule

// File: rtl/axi4_slave_mem_arbiter.sv
// rtl/axi4_slave_mem_arbiter.sv - burst-locked round-robin share of one memory port between write and read paths
// Optional mid-burst hand-over after STARVE_LIMIT beats: define AXI_ARB_STARVE_LIMIT_EN.
module axi4_slave_mem_arbiter
   import axi4_slave_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int RD_LATENCY   = 1,
   parameter int STARVE_LIMIT = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_req,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_be,
   input  logic                    wr_last,
   output logic                    wr_gnt,
   input  logic                    rd_req,
   input  logic [ADDR_WIDTH-1:0]   rd_addr,
   input  logic                    rd_last,
   output logic                    rd_gnt,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_valid,
   output logic                    mem_en,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   arb_state_t state, state_nxt;
   arb_owner_t last_owner, owner_nxt;
   logic       rd_beat;

`ifdef AXI_ARB_STARVE_LIMIT_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] beat_cnt, cnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt <= '0;
      end else begin
         beat_cnt <= cnt_nxt;
      end
   end
`else
   logic unused_starve_limit;
   assign unused_starve_limit = |STARVE_LIMIT;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ARB_IDLE;
         last_owner <= OWN_RD;
      end else begin
         state      <= state_nxt;
         last_owner <= owner_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = last_owner;
      wr_gnt    = 1'b0;
      rd_gnt    = 1'b0;
      case (state)
         ARB_IDLE: begin
            // Contention goes to whoever did not own the previous burst.
            if (wr_req && (!rd_req || last_owner == OWN_RD)) begin
               wr_gnt = 1'b1;
            end else if (rd_req) begin
               rd_gnt = 1'b1;
            end
            if (wr_gnt) begin
               if (wr_last) owner_nxt = OWN_WR;
               else         state_nxt = ARB_WR;
            end else if (rd_gnt) begin
               if (rd_last) owner_nxt = OWN_RD;
               else         state_nxt = ARB_RD;
            end
         end
         ARB_WR: begin
            wr_gnt = wr_req;
            if (wr_req && wr_last) begin
               state_nxt = ARB_IDLE;
               owner_nxt = OWN_WR;
            end
         end
         ARB_RD: begin
            rd_gnt = rd_req;
            if (rd_req && rd_last) begin
               state_nxt = ARB_IDLE;
               owner_nxt = OWN_RD;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
`ifdef AXI_ARB_STARVE_LIMIT_EN
      // The count includes the opening beat granted from IDLE; it is zero whenever no burst is locked.
      cnt_nxt = '0;
      if (state_nxt != ARB_IDLE) begin
         cnt_nxt = beat_cnt;
         if ((wr_gnt || rd_gnt) && beat_cnt < CNT_MAX) cnt_nxt = beat_cnt + CNT_W'(1);
         if (cnt_nxt >= CNT_MAX) begin
            if (state_nxt == ARB_WR && rd_req) begin
               state_nxt = ARB_RD;
               owner_nxt = OWN_WR;
               cnt_nxt   = '0;
            end else if (state_nxt == ARB_RD && wr_req) begin
               state_nxt = ARB_WR;
               owner_nxt = OWN_RD;
               cnt_nxt   = '0;
            end
         end
      end
`endif
      if (rst) begin
         wr_gnt = 1'b0;
         rd_gnt = 1'b0;
      end
   end

   assign rd_beat = rd_req && rd_gnt;

   always_comb begin
      mem_en    = (wr_req && wr_gnt) || rd_beat;
      mem_we    = wr_gnt;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      if (wr_gnt) begin
         mem_addr  = wr_addr;
         mem_wdata = wr_data;
         mem_be    = wr_be;
      end else if (rd_gnt) begin
         mem_addr = rd_addr;
         mem_be   = '1;
      end
   end

   axi4_rd_valid_pipe #(
      .RD_LATENCY(RD_LATENCY)
   ) u_rd_valid_pipe (
      .clk      (clk),
      .rst      (rst),
      .in_valid (rd_beat),
      .out_valid(rd_valid)
   );

   assign rd_data = mem_rdata;

endmodule

// File: tb/tb_axi4_slave_mem_arbiter.sv
// tb/tb_axi4_slave_mem_arbiter.sv - scoreboard bench for the write/read memory arbiter
module tb_axi4_slave_mem_arbiter;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int LAT = 2;
   localparam int SL  = 4;
`ifdef AXI_ARB_STARVE_LIMIT_EN
   localparam int PRE_BEATS = SL;
`else
   localparam int PRE_BEATS = 10;
`endif

   logic          clk, rst;
   logic          wr_req, wr_last, wr_gnt;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [3:0]    wr_be;
   logic          rd_req, rd_last, rd_gnt, rd_valid;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [3:0]    mem_be;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic [DW-1:0] data;
      int            at;
   } rd_exp_t;
   rd_exp_t sb[$];

   axi4_slave_mem_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT), .STARVE_LIMIT(SL)
   ) dut (
      .clk(clk), .rst(rst),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .wr_last(wr_last), .wr_gnt(wr_gnt),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_last(rd_last), .rd_gnt(rd_gnt),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return (a * 32'd3) ^ 32'hC0DE_0000;
   endfunction

   // Memory macro model: returns mem_word(addr) LAT cycles after a read strobe.
   logic [DW-1:0] rdq [LAT];
   always @(posedge clk) begin
      rdq[0] <= (mem_en && !mem_we) ? mem_word(mem_addr) : 32'hDEAD_BEEF;
      for (int i = 1; i < LAT; i++) rdq[i] <= rdq[i-1];
   end
   assign mem_rdata = rdq[LAT-1];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_reqs();
      wr_req  = 1'b0;
      wr_last = 1'b0;
      rd_req  = 1'b0;
      rd_last = 1'b0;
   endtask

   task automatic drive_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [3:0] be, input logic last);
      wr_req = 1'b1; wr_addr = a; wr_data = d; wr_be = be; wr_last = last;
   endtask

   task automatic drive_rd(input logic [AW-1:0] a, input logic last);
      rd_req = 1'b1; rd_addr = a; rd_last = last;
   endtask

   task automatic expect_rd(input logic [AW-1:0] a);
      sb.push_back('{mem_word(a), cyc + LAT});
   endtask

   always @(negedge clk) begin
      check_eq("gnt_exclusive", {1'b0, wr_gnt && rd_gnt}, 0);
      if (rd_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check_eq("rd_valid_spurious", {1'b0, rd_valid}, 0);
         end else begin
            rd_exp_t e;
            e = sb.pop_front();
            check_eq("rd_data", rd_data, e.data);
            check_eq("rd_latency_cycle", cyc, e.at);
         end
      end
   end

   initial begin
      logic [AW-1:0] wa, ra;
      int wb;
      bit rd_done, exp_rd, exp_w;

      rst = 1'b1;
      wr_addr = '0; wr_data = '0; wr_be = 4'hF; rd_addr = '0;
      drive_wr(32'h0, 32'h0, 4'hF, 1'b1);
      drive_rd(32'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("rst_wr_gnt", wr_gnt, 0);
         check_eq("rst_rd_gnt", rd_gnt, 0);
         check_eq("rst_mem_en", mem_en, 0);
         check_eq("rst_rd_valid", rd_valid, 0);
      end
      rst = 1'b0;
      #1;
      check_eq("release_wr_gnt", wr_gnt, 1);
      check_eq("release_rd_gnt", rd_gnt, 0);
      idle_reqs();

      // burst lock: 4-beat write, read arrives on beat 2
      next(); drive_wr(32'h10, 32'h1111_0000, 4'hF, 1'b0);
      @(negedge clk);
      check_eq("lock_b1_wr_gnt", wr_gnt, 1);
      check_eq("lock_b1_mem_en", mem_en, 1);
      check_eq("lock_b1_mem_we", mem_we, 1);
      check_eq("lock_b1_mem_addr", mem_addr, 32'h10);
      check_eq("lock_b1_mem_wdata", mem_wdata, 32'h1111_0000);
      next(); drive_wr(32'h14, 32'h1111_0001, 4'hF, 1'b0); drive_rd(32'h40, 1'b1);
      @(negedge clk);
      check_eq("lock_b2_wr_gnt", wr_gnt, 1);
      check_eq("lock_b2_rd_gnt", rd_gnt, 0);
      check_eq("lock_b2_mem_addr", mem_addr, 32'h14);
      next(); drive_wr(32'h18, 32'h1111_0002, 4'h3, 1'b0);
      @(negedge clk);
      check_eq("lock_b3_rd_gnt", rd_gnt, 0);
      check_eq("lock_b3_mem_be", mem_be, 4'h3);
      next(); drive_wr(32'h1C, 32'h1111_0003, 4'hC, 1'b1);
      @(negedge clk);
      check_eq("lock_b4_wr_gnt", wr_gnt, 1);
      check_eq("lock_b4_rd_gnt", rd_gnt, 0);
      next(); wr_req = 1'b0; wr_last = 1'b0;
      @(negedge clk);
      check_eq("lock_after_rd_gnt", rd_gnt, 1);
      check_eq("lock_after_mem_we", mem_we, 0);
      check_eq("lock_after_mem_be", mem_be, 4'hF);
      check_eq("lock_after_mem_wdata", mem_wdata, 0);
      check_eq("lock_after_mem_addr", mem_addr, 32'h40);
      expect_rd(32'h40);
      next(); idle_reqs();
      @(negedge clk);
      check_eq("idle_mem_en", mem_en, 0);
      check_eq("idle_mem_addr", mem_addr, 0);

      // round robin of single-beat bursts
      wa = 32'h100; ra = 32'h200;
      for (int i = 0; i < 6; i++) begin
         next(); drive_wr(wa, ~wa, 4'hF, 1'b1); drive_rd(ra, 1'b1);
         @(negedge clk);
         exp_w = (i % 2 == 0);
         check_eq("rr_wr_gnt", wr_gnt, exp_w);
         check_eq("rr_rd_gnt", rd_gnt, !exp_w);
         check_eq("rr_mem_addr", mem_addr, exp_w ? wa : ra);
         if (exp_w) begin
            wa = wa + 32'd4;
         end else begin
            expect_rd(ra);
            ra = ra + 32'd4;
         end
      end
      next(); idle_reqs();

      // read burst with a two-cycle request gap keeps the lock
      next(); drive_rd(32'h300, 1'b0);
      @(negedge clk);
      check_eq("gap_b1_rd_gnt", rd_gnt, 1);
      expect_rd(32'h300);
      next(); drive_rd(32'h304, 1'b0); drive_wr(32'h500, 32'h55, 4'hF, 1'b1);
      @(negedge clk);
      check_eq("gap_b2_rd_gnt", rd_gnt, 1);
      check_eq("gap_b2_wr_gnt", wr_gnt, 0);
      expect_rd(32'h304);
      for (int i = 0; i < 2; i++) begin
         next(); rd_req = 1'b0;
         @(negedge clk);
         check_eq("gap_hold_wr_gnt", wr_gnt, 0);
         check_eq("gap_hold_mem_en", mem_en, 0);
      end
      next(); drive_rd(32'h308, 1'b1);
      @(negedge clk);
      check_eq("gap_b3_rd_gnt", rd_gnt, 1);
      check_eq("gap_b3_wr_gnt", wr_gnt, 0);
      expect_rd(32'h308);
      next(); rd_req = 1'b0; rd_last = 1'b0;
      @(negedge clk);
      check_eq("gap_after_wr_gnt", wr_gnt, 1);
      check_eq("gap_after_mem_addr", mem_addr, 32'h500);

      // reset flushes a read still in the valid pipe
      next(); idle_reqs(); drive_rd(32'h600, 1'b1);
      @(negedge clk);
      check_eq("flush_rd_gnt", rd_gnt, 1);
      next(); idle_reqs(); rst = 1'b1;
      @(negedge clk);
      check_eq("flush_rst_mem_en", mem_en, 0);
      next(); rst = 1'b0;
      @(negedge clk);
      check_eq("flush_rd_valid", rd_valid, 0);

      // reset on beat 2 of an 8-beat write burst
      next(); drive_wr(32'h700, 32'h7, 4'hF, 1'b0);
      @(negedge clk);
      check_eq("midrst_b1_wr_gnt", wr_gnt, 1);
      next(); drive_wr(32'h704, 32'h8, 4'hF, 1'b0); rst = 1'b1;
      @(negedge clk);
      check_eq("midrst_b2_wr_gnt", wr_gnt, 0);
      check_eq("midrst_b2_mem_en", mem_en, 0);
      next(); rst = 1'b0; idle_reqs(); drive_rd(32'h800, 1'b1);
      @(negedge clk);
      check_eq("midrst_fresh_rd_gnt", rd_gnt, 1);
      check_eq("midrst_fresh_wr_gnt", wr_gnt, 0);
      check_eq("midrst_rd_valid", rd_valid, 0);
      expect_rd(32'h800);

      // 10-beat write burst against a waiting single-beat read
      wb = 0; rd_done = 1'b0;
      while (wb < 10 || !rd_done) begin
         next(); idle_reqs();
         if (wb < 10) drive_wr(32'hA00 + 32'(wb) * 4, 32'(wb), 4'hF, wb == 9);
         if (!rd_done) drive_rd(32'h900, 1'b1);
         @(negedge clk);
         exp_rd = !rd_done && (wb >= PRE_BEATS);
         check_eq("starve_wr_gnt", wr_gnt, !exp_rd && wb < 10);
         check_eq("starve_rd_gnt", rd_gnt, exp_rd);
         if (exp_rd) begin
            expect_rd(32'h900);
            rd_done = 1'b1;
         end else begin
            wb++;
         end
      end

      next(); idle_reqs();
      repeat (LAT + 2) next();
      check_eq("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axi4_slave_mem_arbiter.md
Name: axi4_slave_mem_arbiter

Overview:
- Shares the slave's single-port memory between the write-data path (mem_wr_* strobes) and the read-data path.
- Grants are burst-locked and alternate round-robin between bursts.
- Muxes the address, data and byte-enables onto the memory port, and returns read data with a valid pipeline matched to memory latency.
- Sits between the AXI4 slave write/read channel FSMs and the memory macro.

Parameters:
- DATA_WIDTH, 32, memory data width in bits.
- ADDR_WIDTH, 32, memory address width.
- RD_LATENCY, 1, cycles from mem_en (read) to mem_rdata valid; legal 1..4.
- STARVE_LIMIT, 16, max consecutive granted beats before forced hand-over (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wr_req  in  1  write path has a beat this cycle
- wr_addr  in  ADDR_WIDTH  write beat address
- wr_data  in  DATA_WIDTH  write beat data
- wr_be  in  DATA_WIDTH/8  write byte enables
- wr_last  in  1  final beat of write burst
- wr_gnt  out  1  write beat accepted this cycle
- rd_req  in  1  read path has a beat this cycle
- rd_addr  in  ADDR_WIDTH  read beat address
- rd_last  in  1  final beat of read burst
- rd_gnt  out  1  read beat issued this cycle
- rd_data  out  DATA_WIDTH  read data (passthrough of mem_rdata)
- rd_valid  out  1  rd_data valid
- mem_en  out  1  memory access strobe
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_be  out  DATA_WIDTH/8  memory byte enables
- mem_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- Clock, reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state:
  - State is ARB_IDLE and last_owner is RD, so WR wins the first contention.
  - The rd_valid pipe and beat counter clear to 0.
  - All gnt and mem_* outputs are 0 while rst is high, because they are gated by rst.
- Beat transfer: occurs when req && gnt. Requesters hold req, addr and data stable until granted.
- FSM states: ARB_IDLE, ARB_WR, ARB_RD.
- ARB_IDLE, combinational same-cycle grant:
  - If only one req is high, grant it.
  - If both are high, grant the requester that is not last_owner.
  - If the granted beat is not last, go to the owner's state. If it is last, stay in IDLE and update last_owner.
- ARB_WR:
  - wr_gnt = wr_req; rd_gnt = 0.
  - On wr_req && wr_last, go to IDLE and set last_owner = WR.
  - A wr_req gap inside a burst keeps the lock.
- ARB_RD: symmetric, using rd_req and rd_last.
- Memory mux (combinational):
  - mem_en = beat transferred; mem_we = wr side granted.
  - mem_addr, mem_wdata and mem_be come from the granted side.
  - On a read, mem_be is all ones and mem_wdata is 0.
  - With nothing granted, mem_addr, mem_wdata and mem_be are 0.
- Read return:
  - rd_valid is a RD_LATENCY-deep shift register of (rd_req && rd_gnt).
  - rd_data = mem_rdata.
  - Back-to-back reads give continuous rd_valid.
- Exclusivity: wr_gnt and rd_gnt are never both 1.
- Reset mid-burst: returns to IDLE next edge and flushes the rd_valid pipe. Only the single beat issued in the reset cycle is lost to the bus; no grant is held.
- Single-beat bursts (last on the first beat) never leave IDLE. Alternation still applies through last_owner.

Optional Feature:
- Macro: AXI_ARB_STARVE_LIMIT_EN.
- When defined:
  - A beat counter (width $clog2(STARVE_LIMIT)+1) counts the owner's granted beats in ARB_WR/ARB_RD.
  - If the count reaches STARVE_LIMIT and the other side's req is high, the FSM transfers ownership directly to the other side's state, mid-burst.
  - The preempted side keeps its burst context externally; it simply sees gnt low.
  - The counter resets on every ownership change.
- When undefined: no counter; the lock holds until the last beat.

Decomposition:
- Package axi4_slave_pkg holds:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_WR, ARB_RD};
  - typedef enum logic {OWN_WR, OWN_RD} arb_owner_t.
- Sub-module axi4_rd_valid_pipe: a parameterised RD_LATENCY shift register with synchronous clear.

Test Plan:
1. Reset check: hold rst high for 3 cycles with wr_req=rd_req=1 -> wr_gnt=rd_gnt=mem_en=rd_valid=0. In the first cycle after release, wr_gnt=1.
2. Burst lock: WR burst of 4 beats at addresses 0x10..0x1C; rd_req rises on beat 2 -> rd_gnt stays 0 until after the wr_last beat. The next cycle rd_gnt=1 and mem_we=0.
3. Round-robin: both sides continuously issue 1-beat bursts -> grants alternate WR,RD,WR,RD. Each read returns rd_valid exactly RD_LATENCY cycles later, with rd_data=mem_rdata.
4. Lock through gap: RD burst of 3 beats with rd_req low for 2 cycles mid-burst while wr_req=1 -> wr_gnt stays 0 until rd_last completes.
5. Mid-burst reset: rst asserted on beat 2 of an 8-beat WR burst -> IDLE next cycle and rd_valid pipe cleared. After release, a fresh RD request is granted immediately.
6. With AXI_ARB_STARVE_LIMIT_EN and STARVE_LIMIT=4: a 10-beat WR burst with rd_req=1 -> WR gets 4 beats, then RD is granted. Without the macro, WR gets all 10 beats first.
